// File: rtl/ucsbece154_mem_arb_pkg.sv
// Shared definitions for the two-requester refill arbiter: FSM encoding,
// requester indices and the block-offset width helper.
package ucsbece154_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    XFER  = 2'd3
  } arb_state_t;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int NUM_REQ    = 2;

  // Byte-offset bits inside one block (block of 32-bit words).
  function automatic int blk_off_w(input int block_words);
    return $clog2(block_words * 4);
  endfunction

endpackage

// File: rtl/ucsbece154_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, on a tie the
// requester selected by ptr wins. Output is one-hot, zero when idle.
module ucsbece154_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pick the winner from the request vector and the fairness pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Read arbiter between the I-cache (r0) and D-cache (r1) refill engines and
// the shared burst memory. One burst at a time, grant held for the whole
// burst, round-robin between bursts.
// Optional WAIT watchdog with sticky timeout_err port: MEM_ARB_TIMEOUT_EN.
module ucsbece154_mem_arbiter
  import ucsbece154_mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_ReadRequest,
  input  logic [31:0] r0_ReadAddress,
  output logic [31:0] r0_DataIn,
  output logic        r0_DataReady,
  output logic        r0_BurstDone,
  input  logic        r1_ReadRequest,
  input  logic [31:0] r1_ReadAddress,
  output logic [31:0] r1_DataIn,
  output logic        r1_DataReady,
  output logic        r1_BurstDone,
  output logic        mem_ReadRequest,
  output logic [31:0] mem_ReadAddress,
  input  logic [31:0] mem_DataIn,
  input  logic        mem_DataReady,
  output logic [1:0]  grant
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int          OFF_W      = blk_off_w(BLOCK_WORDS);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam int          CNT_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  arb_state_t                    state;
  logic                          rr_ptr;
  logic [CNT_W-1:0]              beat_cnt;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            pick;
  logic [NUM_REQ-1:0][31:0]      req_addr;
  logic                          beat;
  logic                          last_beat;

  assign req      = {r1_ReadRequest, r0_ReadRequest};
  assign req_addr = {r1_ReadAddress, r0_ReadAddress};

  // Beats only count once the request has gone out; anything earlier is noise.
  assign beat      = mem_DataReady && (state == WAIT || state == XFER);
  assign last_beat = beat && (beat_cnt == LAST_BEAT);

  ucsbece154_rr_pick2 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  assign r0_DataIn    = mem_DataIn;
  assign r1_DataIn    = mem_DataIn;
  assign r0_DataReady = beat      & grant[REQ_ICACHE];
  assign r1_DataReady = beat      & grant[REQ_DCACHE];
  assign r0_BurstDone = last_beat & grant[REQ_ICACHE];
  assign r1_BurstDone = last_beat & grant[REQ_DCACHE];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  // Arbitration / burst FSM; mem_ReadRequest is a registered one-cycle pulse
  // that is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      grant           <= '0;
      mem_ReadRequest <= 1'b0;
      mem_ReadAddress <= '0;
      rr_ptr          <= 1'b0;
      beat_cnt        <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      mem_ReadRequest <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant           <= pick;
            mem_ReadAddress <= req_addr[pick[REQ_DCACHE]] & ALIGN_MASK;
            mem_ReadRequest <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT, XFER: begin
          if (beat) begin
            if (last_beat) begin
              state    <= IDLE;
              grant    <= '0;
              rr_ptr   <= ~grant[REQ_DCACHE];
              beat_cnt <= '0;
            end else begin
              state    <= XFER;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // Memory never answered: drop the burst, flag it, let the other side in.
          else if (state == WAIT) begin
            if (wait_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
              grant       <= '0;
              rr_ptr      <= ~grant[REQ_DCACHE];
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
